// File: rtl/ports_if.sv
// ============================================================================
// Module : ports_if
// Brief  : Table-write, stage-request and twiddle-stream bundle for ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ports_if #(
  parameter int BIT_WIDTH = 16,
  parameter int SIZE_FFT  = 8,
  parameter int LANES     = 2
);
  localparam int AW = $clog2(SIZE_FFT);

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [BIT_WIDTH-1:0] wr_data;

  logic                 recv_val;
  logic                 recv_rdy;
  logic [AW-1:0]        recv_stage;
  logic                 recv_inverse;

  logic                 send_val;
  logic                 send_rdy;
  logic [BIT_WIDTH-1:0] send_real      [LANES];
  logic [BIT_WIDTH-1:0] send_imaginary [LANES];
  logic                 send_last;

  modport master (
    output wr_en, wr_addr, wr_data,
    output recv_val, recv_stage, recv_inverse,
    input  recv_rdy,
    input  send_val, send_real, send_imaginary, send_last,
    output send_rdy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  recv_val, recv_stage, recv_inverse,
    output recv_rdy,
    output send_val, send_real, send_imaginary, send_last,
    input  send_rdy
  );
endinterface

`default_nettype wire

// File: rtl/ports.sv
// ============================================================================
// Module : ports
// Brief  : Streaming Cooley-Tukey twiddle generator over a loadable sine table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ports #(
  parameter int BIT_WIDTH  = 16,
  parameter int DECIMAL_PT = 8,
  parameter int SIZE_FFT   = 8,
  parameter int LANES      = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  ports_if.slave    bus
);
  localparam int AW       = $clog2(SIZE_FFT);
  localparam int N_STAGES = AW;
  localparam int BEATS    = SIZE_FFT / 2 / LANES;
  localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((SIZE_FFT < 4) || ((SIZE_FFT & (SIZE_FFT - 1)) != 0)) begin : g_bad_size
      $error("SIZE_FFT must be a power of two and at least 4");
    end
    if ((LANES < 1) || ((LANES & (LANES - 1)) != 0) || (LANES > SIZE_FFT / 2)) begin : g_bad_lanes
      $error("LANES must be a power of two no larger than SIZE_FFT/2");
    end
    if ((DECIMAL_PT < 0) || (DECIMAL_PT >= BIT_WIDTH)) begin : g_bad_frac
      $error("DECIMAL_PT must lie inside the word");
    end
  endgenerate

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state;
  logic                 r_rdy;
  logic [AW-1:0]        r_stage;
  logic                 r_inv;
  logic [BW-1:0]        r_beat;
  logic                 r_send_val;
  logic                 r_last;
  logic [BIT_WIDTH-1:0] r_real [LANES];
  logic [BIT_WIDTH-1:0] r_imag [LANES];
  logic [BIT_WIDTH-1:0] r_tbl  [SIZE_FFT];

  logic                 w_fire;
  logic                 w_bypass;
  logic [AW-1:0]        w_stage;
  logic                 w_inv;
  logic [BW-1:0]        w_beat;
  logic                 w_last;
  logic [AW-1:0]        w_mask;
  logic [AW-1:0]        w_shift;
  logic [AW-1:0]        w_idx  [LANES];
  logic [AW-1:0]        w_ridx [LANES];
  logic [BIT_WIDTH-1:0] w_sin  [LANES];
  logic [BIT_WIDTH-1:0] w_cos  [LANES];
  logic [BIT_WIDTH-1:0] w_real [LANES];
  logic [BIT_WIDTH-1:0] w_imag [LANES];

  assign w_fire   = (r_state == S_IDLE) && r_rdy && bus.recv_val;
  // A write in the accepting cycle must already be visible to beat 0.
  assign w_bypass = (r_state == S_IDLE) && bus.wr_en;

  always_comb begin
    w_stage = r_stage;
    w_inv   = r_inv;
    w_beat  = r_beat + BW'(1);
    if (w_fire) begin
      w_stage = (bus.recv_stage >= AW'(N_STAGES)) ? AW'(N_STAGES - 1) : bus.recv_stage;
      w_inv   = bus.recv_inverse;
      w_beat  = '0;
    end
    w_last  = (w_beat == BW'(BEATS - 1));
  end

  // idx = (j mod 2^s) * N / 2^(s+1), i.e. the masked index shifted up by log2(N)-1-s.
  always_comb begin
    w_mask  = (AW'(1) << w_stage) - AW'(1);
    w_shift = AW'(AW - 1) - w_stage;
    for (int l = 0; l < LANES; l++) begin
      w_idx[l]  = ((AW'(w_beat) * AW'(LANES) + AW'(l)) & w_mask) << w_shift;
      w_ridx[l] = w_idx[l] + AW'(SIZE_FFT / 4);
      w_sin[l]  = (w_bypass && (bus.wr_addr == w_idx[l]))  ? bus.wr_data : r_tbl[w_idx[l]];
      w_cos[l]  = (w_bypass && (bus.wr_addr == w_ridx[l])) ? bus.wr_data : r_tbl[w_ridx[l]];
      w_real[l] = w_cos[l];
      w_imag[l] = w_inv ? w_sin[l] : -w_sin[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b0;
      r_stage    <= '0;
      r_inv      <= 1'b0;
      r_beat     <= '0;
      r_send_val <= 1'b0;
      r_last     <= 1'b0;
      r_real     <= '{default: '0};
      r_imag     <= '{default: '0};
      for (int i = 0; i < SIZE_FFT; i++) begin
        r_tbl[i] <= '0;
      end
    end else begin
      if (bus.wr_en && (r_state == S_IDLE)) begin
        r_tbl[bus.wr_addr] <= bus.wr_data;
      end
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (w_fire) begin
            r_state    <= S_RUN;
            r_rdy      <= 1'b0;
            r_stage    <= w_stage;
            r_inv      <= w_inv;
            r_beat     <= w_beat;
            r_send_val <= 1'b1;
            r_last     <= w_last;
            r_real     <= w_real;
            r_imag     <= w_imag;
          end
        end
        S_RUN: begin
          if (bus.send_rdy) begin
            if (r_beat == BW'(BEATS - 1)) begin
              r_state    <= S_IDLE;
              r_rdy      <= 1'b1;
              r_send_val <= 1'b0;
              r_last     <= 1'b0;
            end else begin
              r_beat     <= w_beat;
              r_last     <= w_last;
              r_real     <= w_real;
              r_imag     <= w_imag;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.recv_rdy       = r_rdy;
  assign bus.send_val       = r_send_val;
  assign bus.send_last      = r_last;
  assign bus.send_real      = r_real;
  assign bus.send_imaginary = r_imag;
endmodule

`default_nettype wire

// File: tb/tb_ports.sv
// ============================================================================
// Module : tb_ports
// Brief  : Directed self-checking bench for the streaming twiddle generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ports;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  ports_if #(.BIT_WIDTH(16), .SIZE_FFT(8), .LANES(2)) bus ();

  ports #(
    .BIT_WIDTH (16),
    .DECIMAL_PT(8),
    .SIZE_FFT  (8),
    .LANES     (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [2:0]       stage;
    logic             inv;
    logic [3:0][15:0] re;
    logic [3:0][15:0] im;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] tbl_init [8];

  function automatic vec_t mk(input logic [2:0] s, input logic inv,
                              input logic [15:0] r0, r1, r2, r3,
                              input logic [15:0] i0, i1, i2, i3);
    vec_t v;
    v.stage = s;
    v.inv   = inv;
    v.re[0] = r0; v.re[1] = r1; v.re[2] = r2; v.re[3] = r3;
    v.im[0] = i0; v.im[1] = i1; v.im[2] = i2; v.im[3] = i3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_beat(input string tag, input logic exp_last,
                            input logic [15:0] r0, r1, i0, i1);
    chk({tag, " send_val"}, 32'(bus.send_val), 32'd1);
    chk({tag, " send_last"}, 32'(bus.send_last), 32'(exp_last));
    chk({tag, " real0"}, 32'(bus.send_real[0]), 32'(r0));
    chk({tag, " real1"}, 32'(bus.send_real[1]), 32'(r1));
    chk({tag, " imag0"}, 32'(bus.send_imaginary[0]), 32'(i0));
    chk({tag, " imag1"}, 32'(bus.send_imaginary[1]), 32'(i1));
  endtask

  // Called at a negedge while idle; returns at the negedge where beat 0 is shown.
  task automatic request(input string tag, input logic [2:0] s, input logic inv);
    chk({tag, " recv_rdy before request"}, 32'(bus.recv_rdy), 32'd1);
    bus.recv_val     = 1'b1;
    bus.recv_stage   = s;
    bus.recv_inverse = inv;
    @(negedge clk);
    bus.recv_val = 1'b0;
    chk({tag, " recv_rdy in RUN"}, 32'(bus.recv_rdy), 32'd0);
  endtask

  task automatic drain();
    bus.send_rdy = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int xfers;
    logic [4:0] pat;
    string tag;

    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.recv_val = 1'b0;
    bus.recv_stage = '0;
    bus.recv_inverse = 1'b0;
    bus.send_rdy = 1'b1;

    tbl_init[0] = 16'h0000; tbl_init[1] = 16'h00B5; tbl_init[2] = 16'h0100; tbl_init[3] = 16'h00B5;
    tbl_init[4] = 16'h0000; tbl_init[5] = 16'hFF4B; tbl_init[6] = 16'hFF00; tbl_init[7] = 16'hFF4B;

    vecs[0] = mk(3'd0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[1] = mk(3'd2, 1'b0, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B);
    vecs[2] = mk(3'd2, 1'b1, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'h0000, 16'h00B5, 16'h0100, 16'h00B5);
    vecs[3] = mk(3'd1, 1'b0, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'hFF00);
    vecs[4] = mk(3'd1, 1'b1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100);
    vecs[5] = mk(3'd5, 1'b0, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B);
    vecs[6] = mk(3'd3, 1'b1, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'h0000, 16'h00B5, 16'h0100, 16'h00B5);
    vecs[7] = mk(3'd0, 1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset recv_rdy", 32'(bus.recv_rdy), 32'd0);
    chk("reset send_val", 32'(bus.send_val), 32'd0);
    chk("reset send_last", 32'(bus.send_last), 32'd0);
    chk("reset real0", 32'(bus.send_real[0]), 32'd0);
    chk("reset imag1", 32'(bus.send_imaginary[1]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset recv_rdy", 32'(bus.recv_rdy), 32'd1);

    for (int m = 0; m < 8; m++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = 3'(m);
      bus.wr_data = tbl_init[m];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;

    // Table-driven stages with send_rdy held high
    for (int v = 0; v < 8; v++) begin
      tag = $sformatf("vec%0d", v);
      bus.send_rdy = 1'b1;
      request(tag, vecs[v].stage, vecs[v].inv);
      for (int b = 0; b < 2; b++) begin
        check_beat($sformatf("%s beat%0d", tag, b), (b == 1),
                   vecs[v].re[2*b], vecs[v].re[2*b+1], vecs[v].im[2*b], vecs[v].im[2*b+1]);
        @(negedge clk);
      end
      chk({tag, " send_val after stage"}, 32'(bus.send_val), 32'd0);
      chk({tag, " recv_rdy after stage"}, 32'(bus.recv_rdy), 32'd1);
    end

    // Backpressure on stage 1: send_rdy = 0,0,1,0,1
    pat = 5'b10100;
    xfers = 0;
    request("bp", 3'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.send_rdy = pat[k];
      check_beat($sformatf("bp cyc%0d", k), (xfers == 1), 16'h0100, 16'h0000, 16'h0000, 16'hFF00);
      if (bus.send_val && pat[k]) xfers++;
      @(negedge clk);
    end
    chk("bp transfers", 32'(xfers), 32'd2);
    chk("bp send_val after", 32'(bus.send_val), 32'd0);
    chk("bp recv_rdy after", 32'(bus.recv_rdy), 32'd1);

    // Write during RUN is ignored
    bus.send_rdy = 1'b0;
    request("runwr", 3'd2, 1'b0);
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 16'h8000;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check_beat("runwr held", 1'b0, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B);
    drain();
    bus.send_rdy = 1'b0;
    request("runwr again", 3'd2, 1'b0);
    check_beat("runwr again beat0", 1'b0, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B);
    drain();

    // IDLE write, then a write landing in the same cycle as the request
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 16'h8000;
    @(negedge clk);
    bus.wr_addr = 3'd3;
    bus.wr_data = 16'h0042;
    request("idlewr", 3'd2, 1'b0);
    bus.wr_en = 1'b0;
    check_beat("idlewr beat0", 1'b0, 16'h0100, 16'h0042, 16'h0000, 16'h8000);
    drain();

    // Reset mid-RUN with backpressure
    bus.send_rdy = 1'b0;
    request("midrst", 3'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst send_val", 32'(bus.send_val), 32'd0);
    chk("midrst recv_rdy in reset", 32'(bus.recv_rdy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst recv_rdy after", 32'(bus.recv_rdy), 32'd1);
    bus.send_rdy = 1'b1;
    request("cleared", 3'd0, 1'b0);
    check_beat("cleared beat0", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    check_beat("cleared beat1", 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("cleared recv_rdy after", 32'(bus.recv_rdy), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

`default_nettype wire
